// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
//
// Sequencing controller for the shared 32-round restoring divider used by the
// M-extension path. Accepts DIV/DIVU/REM/REMU requests over a valid/ready
// handshake, feeds operand magnitudes to the divider and holds its start line
// for the whole run. It then applies the sign and divide-by-zero fix-up and
// returns the 32-bit result together with the destination tag.
//
// Optional feature macro: DIV_SEQ_FASTPATH_EN
//   When defined, divide-by-zero and signed-overflow requests bypass the
//   divider (IDLE -> FIX). Result values are identical in both builds.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   in_valid      request valid
//   in_ready      request accepted when in_valid & in_ready
//   in_op         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   in_rs1        dividend
//   in_rs2        divisor
//   in_rd         destination tag, returned unchanged
//   flush         abort any accepted or in-flight operation
//   out_valid     result valid
//   out_ready     result consumed when out_valid & out_ready
//   out_result    quotient or remainder
//   out_rd        tag of the result
//   busy          high in any state other than IDLE
//   div_start     divider start/enable, high for the whole run
//   div_dividend  magnitude dividend to the divider
//   div_divisor   magnitude divisor to the divider
//   div_rdy       divider completion pulse
//   div_result    {quotient[63:32], remainder[31:0]} from the divider
// ---------------------------------------------------------------------------
module div_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        busy,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_rdy,
    input  logic [63:0] div_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  op_q;
    logic [4:0]  rd_q;
    logic        s1_q;
    logic        s2_q;
    logic        zero_q;
    logic [31:0] rs1_q;
    logic [31:0] dividend_q;
    logic [31:0] divisor_q;
    logic [63:0] res_q;
    logic [31:0] out_result_q;

    logic        accept;
    logic        in_signed;
    logic        in_zero;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        fast_path;

    logic        sgn;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] fixed;

    // Request side: op[0] low marks the signed variants (DIV, REM); their
    // negative operands are converted to magnitudes before entering the
    // divider.
    assign in_ready  = (state == IDLE) & ~flush;
    assign accept    = in_valid & in_ready;
    assign in_signed = ~in_op[0];
    assign in_zero   = (in_rs2 == 32'd0);
    assign mag1      = (in_signed & in_rs1[31]) ? (~in_rs1 + 32'd1) : in_rs1;
    assign mag2      = (in_signed & in_rs2[31]) ? (~in_rs2 + 32'd1) : in_rs2;

    // Special cases whose result does not depend on the divider may skip the
    // run entirely. Signed overflow magnitude-divides 0x80000000 by 1, so
    // preloading {mag1, 0} as the raw result lets the ordinary fix-up
    // produce 0x80000000 / 0.
`ifdef DIV_SEQ_FASTPATH_EN
    logic in_ovf;
    assign in_ovf    = in_signed & (in_rs1 == 32'h8000_0000) & (in_rs2 == 32'hFFFF_FFFF);
    assign fast_path = in_zero | in_ovf;
`else
    assign fast_path = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Flush wins over every other transition, including
    // the accept and the output handshake in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)    state_next = fast_path ? FIX : RUN;
            RUN:  if (div_rdy)   state_next = FIX;
            FIX:                 state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Fix-up: quotient is negative when signs differ, remainder takes the
    // dividend's sign. A zero divisor overrides both with the architectural
    // all-ones quotient / original dividend.
    always_comb begin
        sgn   = ~op_q[0];
        q_neg = sgn & (s1_q ^ s2_q);
        r_neg = sgn & s1_q;
        quot  = res_q[63:32];
        rem   = res_q[31:0];
        fixed = 32'd0;
        if (zero_q) begin
            fixed = op_q[1] ? rs1_q : 32'hFFFF_FFFF;
        end else if (op_q[1]) begin
            fixed = r_neg ? (~rem + 32'd1) : rem;
        end else begin
            fixed = q_neg ? (~quot + 32'd1) : quot;
        end
    end

    // Datapath registers: operands and request context are latched on
    // accept, the divider result in the cycle div_rdy is seen during RUN,
    // and the fixed-up result in FIX so it stays stable throughout DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q         <= 2'd0;
            rd_q         <= 5'd0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            zero_q       <= 1'b0;
            rs1_q        <= 32'd0;
            dividend_q   <= 32'd0;
            divisor_q    <= 32'd0;
            res_q        <= 64'd0;
            out_result_q <= 32'd0;
        end else begin
            if (accept) begin
                op_q       <= in_op;
                rd_q       <= in_rd;
                s1_q       <= in_rs1[31];
                s2_q       <= in_rs2[31];
                zero_q     <= in_zero;
                rs1_q      <= in_rs1;
                dividend_q <= mag1;
                divisor_q  <= mag2;
                if (fast_path) begin
                    res_q <= {mag1, 32'd0};
                end
            end
            if ((state == RUN) && div_rdy && !flush) begin
                res_q <= div_result;
            end
            if ((state == FIX) && !flush) begin
                out_result_q <= fixed;
            end
        end
    end

    assign div_start    = (state == RUN);
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign busy         = (state != IDLE);
    assign out_valid    = (state == DONE);
    assign out_result   = out_result_q;
    assign out_rd       = rd_q;

endmodule
